bcd_disp_driver: RTL and testbench
==================================

BCD_DISP_DRIVER -- requirements
Module: bcd_disp_driver

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk_pre cycles per digit-position dwell (>=2).
REQ-002 clk_pre  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 value  input  32  unsigned binary value to display; sampled only at conversion start.
REQ-005 disp_7seg  output  11  [10:7] active-low anode select, [6:0] active-low segments a..g (bit6=a).
REQ-006 busy  output  1  high while a conversion is in progress (SHIFT or COMMIT).
REQ-007 digits_valid  output  1  high once at least one conversion has committed since reset.
REQ-008 ovf  output  1  committed value exceeded 9999.

Function
REQ-009 Converter FSM SHALL have states IDLE, SHIFT, COMMIT.
REQ-010 IDLE: when value != last captured value, or no conversion has occurred since reset, SHALL capture value, go to SHIFT next cycle.
REQ-011 Capture SHALL clamp: value > 9999 sets pending ovf and loads 0 into the shift register; otherwise loads value[13:0].
REQ-012 SHIFT SHALL run exactly 14 double-dabble iterations, one per cycle: add 3 to every BCD nibble >= 5, then shift left 1.
REQ-013 After the 14th iteration, SHALL go to COMMIT; COMMIT SHALL write the 4 BCD digits and ovf to display registers, set digits_valid, return to IDLE.
REQ-014 Latency from capture edge to updated display registers SHALL be 16 clk_pre cycles.
REQ-015 value changes during SHIFT/COMMIT SHALL be ignored; the new value is captured on the first IDLE cycle after COMMIT.
REQ-016 Display registers SHALL hold their last committed contents throughout a conversion (no partial digits shown).
REQ-017 Scan divider SHALL count 0..SCAN_DIV-1; on terminal count, wrap to 0 and advance disp_pos 0->1->2->3->0.
REQ-018 Anode/digit map: pos0 1110 ones, pos1 1101 tens, pos2 1011 hundreds, pos3 0111 thousands.
REQ-019 Segment encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; others 1111111.
REQ-020 ovf=1 SHALL show dash (1111110) on all four positions.
REQ-021 digits_valid=0 SHALL show blank segments (1111111) with anodes still scanning.
REQ-022 Leading zeros SHALL be displayed (no suppression).
REQ-023 disp_7seg SHALL be a registered output, updated one cycle after disp_pos/digit registers change.
REQ-024 Scan divider and converter SHALL run independently; a COMMIT never resets the scan position.

Reset
REQ-025 Reset SHALL force: FSM=IDLE, shift register=0, divider=0, disp_pos=0, digits=0, busy=0, digits_valid=0, ovf=0.
REQ-026 disp_7seg reset value SHALL be 11'b1110_1111111.
REQ-027 Reset asserted mid-conversion SHALL abort it with no commit; first IDLE cycle after release captures value.
REQ-028 Reset SHALL win over any simultaneous commit or scan advance.

Structure
REQ-029 Package disp_pkg SHALL hold: converter state enum, 4 anode patterns, segment codes for 0-9/dash/blank, MAX_DISP=9999.
REQ-030 Sub-module bin2bcd_seq SHALL contain the IDLE/SHIFT/COMMIT converter (14-bit in, 16-bit BCD out, start/busy/done); scan logic and segment encode stay in bcd_disp_driver.

Verification (SCAN_DIV=4)
REQ-031 Release reset with value=5050 -> busy high cycles 1-15 after capture, digits_valid rises 16 cycles after capture, scan shows 0,5,0,5 for pos0..3 (1110_0000001, 1101_0100100, ...).
REQ-032 value=9999 -> all positions 0000100, ovf=0; then value=10000 -> all positions 1111110, ovf=1.
REQ-033 value 1234->0007 changed at SHIFT iteration 5 -> 1234 commits first, 0007 commits 16 cycles after the next IDLE capture; display never shows mixed digits.
REQ-034 Reset asserted at SHIFT iteration 8 -> digits_valid=0, disp_7seg=1110_1111111 next cycle, no commit observed.
REQ-035 Hold value=0, run 32 cycles -> anodes cycle 1110,1101,1011,0111 every 4 cycles, wrap to 1110, segments 0000001 each position.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit multiplexed BCD display driver:
// converter states, anode patterns, segment codes and the display limit.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  localparam int unsigned MAX_DISP = 9999;
  localparam int BIN_W = 14;
  localparam int BCD_W = 16;
  localparam int ITERS = 14;

  localparam logic [3:0] AN_POS0 = 4'b1110;
  localparam logic [3:0] AN_POS1 = 4'b1101;
  localparam logic [3:0] AN_POS2 = 4'b1011;
  localparam logic [3:0] AN_POS3 = 4'b0111;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] anode_for(input logic [1:0] pos);
    case (pos)
      2'd0:    return AN_POS0;
      2'd1:    return AN_POS1;
      2'd2:    return AN_POS2;
      default: return AN_POS3;
    endcase
  endfunction

  function automatic logic [6:0] seg_for_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4 BCD digits, one
// add-3/shift iteration per clock, result held in bcd until the next commit.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic                clk_pre,
  input  logic                reset,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic [BCD_W-1:0]    bcd,
  output logic                busy,
  output logic                done
);

  conv_state_e              state_q, state_d;
  logic [BIN_W+BCD_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [3:0]               iter_q, iter_d;
  logic [BIN_W+BCD_W-1:0]   adj_sr;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    adj_sr  = sr_q;
    // Nibbles of 5 or more would overflow past 9 once doubled.
    for (int i = 0; i < 4; i++) begin
      if (adj_sr[BIN_W+4*i +: 4] >= 4'd5)
        adj_sr[BIN_W+4*i +: 4] = adj_sr[BIN_W+4*i +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin};
          iter_d  = 4'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d   = {adj_sr[BIN_W+BCD_W-2:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'(ITERS - 1))
          state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        bcd_d   = sr_q[BIN_W+BCD_W-1:BIN_W];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pre) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_COMMIT);

endmodule

// File: rtl/bcd_disp_driver.sv
// Multiplexed 4-digit 7-segment driver: converts a 32-bit value to BCD in the
// background and scans the last committed digits across the anodes.
module bcd_disp_driver
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk_pre,
  input  logic        reset,
  input  logic [31:0] value,
  output logic [10:0] disp_7seg,
  output logic        busy,
  output logic        digits_valid,
  output logic        ovf
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [31:0]      last_q, last_d;
  logic             captured_q, captured_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       pos_q, pos_d;
  logic [10:0]      disp_q, disp_d;

  logic             conv_start;
  logic             conv_busy;
  logic             conv_done;
  logic [BIN_W-1:0] conv_bin;
  logic [BCD_W-1:0] bcd;
  logic [3:0]       digit;
  logic [6:0]       seg;

  assign conv_start = !conv_busy && (!captured_q || (value != last_q));
  assign conv_bin   = (value > MAX_DISP) ? '0 : value[BIN_W-1:0];

  bin2bcd_seq u_conv (
    .clk_pre (clk_pre),
    .reset   (reset),
    .start   (conv_start),
    .bin     (conv_bin),
    .bcd     (bcd),
    .busy    (conv_busy),
    .done    (conv_done)
  );

  always_comb begin
    last_d     = last_q;
    captured_d = captured_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    valid_d    = valid_q;
    div_d      = div_q;
    pos_d      = pos_q;
    if (conv_start) begin
      last_d     = value;
      captured_d = 1'b1;
      ovf_pend_d = (value > MAX_DISP);
    end
    if (conv_done) begin
      ovf_d   = ovf_pend_q;
      valid_d = 1'b1;
    end
    // Scan runs free of the converter; a commit never disturbs the position.
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      pos_d = pos_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    case (pos_q)
      2'd0:    digit = bcd[3:0];
      2'd1:    digit = bcd[7:4];
      2'd2:    digit = bcd[11:8];
      default: digit = bcd[15:12];
    endcase
    if (!valid_q)
      seg = SEG_BLANK;
    else if (ovf_q)
      seg = SEG_DASH;
    else
      seg = seg_for_digit(digit);
    disp_d = {anode_for(pos_q), seg};
  end

  always_ff @(posedge clk_pre) begin
    if (reset) begin
      last_q     <= '0;
      captured_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      div_q      <= '0;
      pos_q      <= '0;
      disp_q     <= 11'b1110_1111111;
    end else begin
      last_q     <= last_d;
      captured_q <= captured_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      div_q      <= div_d;
      pos_q      <= pos_d;
      disp_q     <= disp_d;
    end
  end

  assign disp_7seg    = disp_q;
  assign busy         = conv_busy;
  assign digits_valid = valid_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_bcd_disp_driver.sv
// Self-checking bench for bcd_disp_driver with SCAN_DIV=4: vector table of
// values with expected digits, a per-anode scoreboard, and timing sequences.
module tb_bcd_disp_driver;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SD = 7'b1111110;

  typedef struct packed {
    logic [31:0]     value;
    logic            exp_ovf;
    logic [3:0][6:0] exp_seg;
  } vec_t;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
  } exp_t;

  logic        clk_pre = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = '0;
  logic [10:0] disp_7seg;
  logic        busy;
  logic        digits_valid;
  logic        ovf;

  int checks = 0;
  int passes = 0;
  exp_t sb_q[$];
  vec_t vecs[5];

  bcd_disp_driver #(.SCAN_DIV(4)) dut (
    .clk_pre      (clk_pre),
    .reset        (reset),
    .value        (value),
    .disp_7seg    (disp_7seg),
    .busy         (busy),
    .digits_valid (digits_valid),
    .ovf          (ovf)
  );

  always #5 clk_pre = ~clk_pre;

  function automatic logic [3:0] anode_of(input int idx);
    case (idx)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic int idx_of(input logic [3:0] an);
    case (an)
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_pre);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    value = v;
  endtask

  task automatic waitBusy(input logic lvl, input int bound, input string name);
    int n = 0;
    while (busy !== lvl && n < bound) begin
      tick();
      n++;
    end
    checkOutput(name, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic pushExpected(input logic [3:0][6:0] segs);
    for (int i = 0; i < 4; i++) sb_q.push_back('{anode: anode_of(i), seg: segs[i]});
  endtask

  task automatic collectDisplay(input string name);
    int n = 0;
    tick();
    while (sb_q.size() > 0 && n < 40) begin
      for (int i = 0; i < sb_q.size(); i++) begin
        if (sb_q[i].anode == disp_7seg[10:7]) begin
          checkOutput(name, {21'd0, disp_7seg}, {21'd0, sb_q[i].anode, sb_q[i].seg});
          sb_q.delete(i);
          break;
        end
      end
      tick();
      n++;
    end
    if (sb_q.size() > 0) begin
      checkOutput({name, " timeout"}, sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  // Follows one conversion from its capture cycle (cycle 1) to the commit.
  task automatic checkLatency(input string name);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      if (c <= 15) begin
        checkOutput({name, " busy"}, {31'd0, busy}, 32'd1);
        checkOutput({name, " valid low"}, {31'd0, digits_valid}, 32'd0);
      end else begin
        checkOutput({name, " busy done"}, {31'd0, busy}, 32'd0);
        checkOutput({name, " valid rise"}, {31'd0, digits_valid}, 32'd1);
      end
    end
  endtask

  initial begin
    logic [3:0][6:0] seg1234;
    int start_idx;
    int n;

    vecs[0] = '{value: 32'd9999,  exp_ovf: 1'b0, exp_seg: {S9, S9, S9, S9}};
    vecs[1] = '{value: 32'd10000, exp_ovf: 1'b1, exp_seg: {SD, SD, SD, SD}};
    vecs[2] = '{value: 32'd42,    exp_ovf: 1'b0, exp_seg: {S0, S0, S4, S2}};
    vecs[3] = '{value: 32'd3086,  exp_ovf: 1'b0, exp_seg: {S3, S0, S8, S6}};
    vecs[4] = '{value: 32'd0,     exp_ovf: 1'b0, exp_seg: {S0, S0, S0, S0}};
    seg1234 = {S1, S2, S3, S4};

    applyStimulus(32'd5050);
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("reset disp", {21'd0, disp_7seg}, {21'd0, 11'b1110_1111111});
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset valid", {31'd0, digits_valid}, 32'd0);
    checkOutput("reset ovf", {31'd0, ovf}, 32'd0);

    reset = 1'b0;
    waitBusy(1'b1, 4, "5050 capture");
    checkLatency("5050");
    pushExpected({S5, S0, S5, S0});
    collectDisplay("5050 scan");

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].value);
      waitBusy(1'b1, 4, "vec capture");
      waitBusy(1'b0, 20, "vec commit");
      checkOutput("vec ovf", {31'd0, ovf}, {31'd0, vecs[v].exp_ovf});
      checkOutput("vec valid", {31'd0, digits_valid}, 32'd1);
      pushExpected(vecs[v].exp_seg);
      collectDisplay("vec scan");
    end

    // Value 0 held: anodes step every 4 cycles with zeros on every position.
    n = 0;
    start_idx = idx_of(disp_7seg[10:7]);
    tick();
    while (idx_of(disp_7seg[10:7]) == start_idx && n < 6) begin
      tick();
      n++;
    end
    checkOutput("scan step found", {31'd0, n < 6}, 32'd1);
    start_idx = idx_of(disp_7seg[10:7]);
    for (int j = 0; j < 32; j++) begin
      checkOutput("scan zero", {21'd0, disp_7seg},
                  {21'd0, anode_of((start_idx + j / 4) % 4), S0});
      tick();
    end

    // Value changes mid-conversion: 1234 commits first, 7 is picked up after.
    applyStimulus(32'd1234);
    waitBusy(1'b1, 4, "1234 capture");
    repeat (5) tick();
    applyStimulus(32'd7);
    waitBusy(1'b0, 20, "1234 commit");
    for (int j = 1; j <= 16; j++) begin
      tick();
      checkOutput("hold 1234", {21'd0, disp_7seg},
                  {21'd0, disp_7seg[10:7], seg1234[idx_of(disp_7seg[10:7])]});
      if (j == 1 || j == 15) checkOutput("7 busy", {31'd0, busy}, 32'd1);
      if (j == 16) checkOutput("7 commit", {31'd0, busy}, 32'd0);
    end
    pushExpected({S0, S0, S0, S7});
    collectDisplay("0007 scan");

    // Reset during the 8th iteration aborts; the value is recaptured afterwards.
    applyStimulus(32'd321);
    waitBusy(1'b1, 4, "321 capture");
    repeat (8) tick();
    reset = 1'b1;
    tick();
    checkOutput("abort valid", {31'd0, digits_valid}, 32'd0);
    checkOutput("abort disp", {21'd0, disp_7seg}, {21'd0, 11'b1110_1111111});
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    waitBusy(1'b1, 4, "321 recapture");
    checkLatency("321");
    pushExpected({S0, S3, S2, S1});
    collectDisplay("0321 scan");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
